decoder_sched: RTL

- Iteration scheduler for the neural min-sum decoder datapath: variable layer, check layer, then output (LLR-sum) layer.
- Accepts one channel-LLR frame per handshake.
- Sequences N_ITER variable/check passes by pulsing layer enables with per-layer latencies, then runs the output layer and presents the result.
- Sits between the frame input FIFO and the layer pipeline. Drives capture/enable strobes only; no LLR data passes through it.

---
 rtl/decoder_pkg.sv | 23 ++
 rtl/decoder_sched_if.sv | 30 +++
 rtl/decoder_sched_phase_timer.sv | 26 ++
 rtl/decoder_sched.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the min-sum decoder scheduler and layer modules.
package decoder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VAR,
    CHK,
    OUT,
    DONE
  } sched_state_t;

  // Bits needed to hold values 0..max_val (never less than one bit).
  function automatic int width_for(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/decoder_sched_if.sv
// Control/handshake bundle between the iteration scheduler and its neighbours.
interface decoder_sched_if #(
  parameter int ITER_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic              llr_load;
  logic              first_iter;
  logic              var_en;
  logic              chk_en;
  logic              out_en;
  logic [ITER_W-1:0] iter_idx;
  logic              syndrome_ok;
  logic              out_valid;
  logic              out_ready;
  logic              converged;
  logic [ITER_W-1:0] iters_used;

  modport master (
    input  in_valid, syndrome_ok, out_ready,
    output in_ready, llr_load, first_iter, var_en, chk_en, out_en,
           iter_idx, out_valid, converged, iters_used
  );

  modport slave (
    output in_valid, syndrome_ok, out_ready,
    input  in_ready, llr_load, first_iter, var_en, chk_en, out_en,
           iter_idx, out_valid, converged, iters_used
  );
endinterface

// File: rtl/decoder_sched_phase_timer.sv
// Loadable down-counter timing one layer phase; done while the count sits at zero.
module sched_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         done
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/decoder_sched.sv
// Iteration scheduler: strobes variable/check/output layers for N_ITER passes per frame.
// Optional early termination on syndrome_ok is enabled by DECODER_SCHED_EARLY_TERM_EN.
module decoder_sched
  import decoder_pkg::*;
#(
  parameter int N_ITER = 5,
  parameter int LAT_V  = 1,
  parameter int LAT_C  = 1,
  parameter int LAT_O  = 1,
  parameter int ITER_W = $clog2(N_ITER + 1)
) (
  input  logic            clk,
  input  logic            rst,
  decoder_sched_if.master bus
);

  localparam int PW = width_for(max3(LAT_V, LAT_C, LAT_O));
  localparam logic [PW-1:0]     LOAD_V    = PW'(LAT_V - 1);
  localparam logic [PW-1:0]     LOAD_C    = PW'(LAT_C - 1);
  localparam logic [PW-1:0]     LOAD_O    = PW'(LAT_O - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);

  sched_state_t      state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] used_q, used_d;
  logic              conv_q, conv_d;
  logic              ph_load;
  logic [PW-1:0]     ph_val;
  logic [PW-1:0]     ph_cnt;
  logic              ph_done;

  sched_phase_timer #(.W(PW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .cnt      (ph_cnt),
    .done     (ph_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
      used_q  <= '0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      used_q  <= used_d;
      conv_q  <= conv_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default up front so no path can infer a latch.
    state_d = state_q;
    iter_d  = iter_q;
    used_d  = used_q;
    conv_d  = conv_q;
    ph_load = 1'b0;
    ph_val  = '0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = VAR;
          iter_d  = '0;
          ph_load = 1'b1;
          ph_val  = LOAD_V;
        end
      end
      VAR: begin
        if (ph_done) begin
          state_d = CHK;
          ph_load = 1'b1;
          ph_val  = LOAD_C;
        end
      end
      CHK: begin
        if (ph_done) begin
`ifdef DECODER_SCHED_EARLY_TERM_EN
          state_d = OUT;
          ph_load = 1'b1;
          ph_val  = LOAD_O;
`else
          ph_load = 1'b1;
          if (iter_q == LAST_ITER) begin
            state_d = OUT;
            ph_val  = LOAD_O;
          end else begin
            state_d = VAR;
            iter_d  = iter_q + 1'b1;
            ph_val  = LOAD_V;
          end
`endif
        end
      end
      OUT: begin
        if (ph_done) begin
`ifdef DECODER_SCHED_EARLY_TERM_EN
          if (bus.syndrome_ok || (iter_q == LAST_ITER)) begin
            state_d = DONE;
            used_d  = iter_q + 1'b1;
            conv_d  = bus.syndrome_ok;
          end else begin
            state_d = VAR;
            iter_d  = iter_q + 1'b1;
            ph_load = 1'b1;
            ph_val  = LOAD_V;
          end
`else
          state_d = DONE;
          used_d  = iter_q + 1'b1;
`endif
        end
      end
      DONE: begin
        // A waiting frame stays in the FIFO until the result has been taken.
        if (bus.out_ready) begin
          state_d = IDLE;
          iter_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef DECODER_SCHED_EARLY_TERM_EN
  logic unused_syndrome;
  assign unused_syndrome = bus.syndrome_ok;
`endif

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.llr_load   = (state_q == IDLE) && bus.in_valid;
  assign bus.var_en     = (state_q == VAR);
  assign bus.chk_en     = (state_q == CHK);
  assign bus.out_en     = (state_q == OUT);
  assign bus.first_iter = (state_q == VAR) && (iter_q == '0);
  assign bus.iter_idx   = iter_q;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.converged  = conv_q;
  assign bus.iters_used = used_q;

endmodule
